// File: rtl/mem_access_unit.sv
// Memory access stage: one-shot fetch/load/store requests run over a req/ack bus
// with wait-state timeout; holds IR and MDR, does little-endian lane steering.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        ir_load_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [31:0] instr_o,
  output logic [31:0] mdr_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [1:0]  r_addr_lo;
  logic [1:0]  r_size;
  logic        r_uns, r_we, r_irl;
  logic [7:0]  r_cnt;
  logic        r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [31:0] r_instr, r_mdr;

  logic [1:0]  w_size;
  logic        w_we, w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift, w_load;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Fetches are always treated as word reads regardless of size_i/we_i.
  always_comb begin
    w_size  = ir_load_i ? 2'b00 : size_i;
    w_we    = we_i & ~ir_load_i;
    w_be    = 4'b1111;
    w_wdata = '0;
    case (w_size)
      2'b01:   w_misalign = addr_i[0];
      2'b10:   w_misalign = 1'b0;
      default: w_misalign = |addr_i[1:0];
    endcase
    if (w_we) begin
      case (w_size)
        2'b01: begin
          w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{wdata_i[15:0]}};
        end
        2'b10: begin
          w_be    = 4'b0001 << addr_i[1:0];
          w_wdata = {4{wdata_i[7:0]}};
        end
        default: w_wdata = wdata_i;
      endcase
    end
  end

  always_comb begin
    w_shift = mem_rdata_i >> {r_addr_lo, 3'b000};
    w_byte  = w_shift[7:0];
    w_half  = r_addr_lo[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (r_size)
      2'b01:   w_load = r_uns ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      2'b10:   w_load = r_uns ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      default: w_load = mem_rdata_i;
    endcase
  end

  // Ack is tested before the timeout so an ack on the final wait cycle wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_next = w_misalign ? S_ERR : S_REQ;
      S_REQ: begin
        if (mem_ack_i)            w_next = S_DONE;
        else if (r_cnt == LP_LAST) w_next = S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_lo   <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_we        <= 1'b0;
      r_irl       <= 1'b0;
      r_cnt       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_instr     <= '0;
      r_mdr       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_addr_lo <= addr_i[1:0];
          r_size    <= w_size;
          r_uns     <= uns_i;
          r_we      <= w_we;
          r_irl     <= ir_load_i;
          r_cnt     <= '0;
          if (!w_misalign) begin
            r_mem_we    <= w_we;
            r_mem_addr  <= {addr_i[31:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            if (r_irl)      r_instr <= mem_rdata_i;
            else if (!r_we) r_mdr   <= w_load;
          end
          if (w_next != S_REQ) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_o   = (r_state == S_REQ);
  assign busy_o      = (r_state == S_REQ);
  assign done_o      = (r_state == S_DONE);
  assign err_o       = (r_state == S_ERR);
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_be_o    = r_mem_be;
  assign mem_wdata_o = r_mem_wdata;
  assign instr_o     = r_instr;
  assign mdr_o       = r_mdr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: the bench acts as the memory, hand-computed expectations.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst, start_i, ir_load_i, we_i, uns_i, mem_ack_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic        mem_req_o, mem_we_o, busy_o, done_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, instr_o, mdr_o;
  logic [3:0]  mem_be_o;

  int n_checks = 0;
  int n_err    = 0;

  int          req_cycles, lat;
  logic        saw_done, saw_err, bus_stable;
  logic        b_we;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_be;

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ir_load_i(ir_load_i), .we_i(we_i),
    .size_i(size_i), .uns_i(uns_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .instr_o(instr_o), .mdr_o(mdr_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request, plays memory (ack after ack_after wait cycles, <0 = never),
  // records bus fields and latency; returns one cycle after done/err.
  task automatic access(input logic irl, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_after, input logic [31:0] rd, input logic restart);
    ir_load_i = irl; we_i = we; size_i = sz; uns_i = uns; addr_i = a; wdata_i = wd;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; ir_load_i = 1'b0; we_i = ~we; size_i = 2'b10; uns_i = ~uns;
    addr_i = 32'hFFFF_FFFF; wdata_i = 32'h5555_AAAA;
    req_cycles = 0; lat = 0; saw_done = 1'b0; saw_err = 1'b0; bus_stable = 1'b1;
    b_we = 1'b0; b_addr = '0; b_be = '0; b_wdata = '0;
    for (int c = 0; c < 60; c++) begin
      if (mem_req_o) begin
        if (req_cycles == 0) begin
          b_we = mem_we_o; b_addr = mem_addr_o; b_be = mem_be_o; b_wdata = mem_wdata_o;
        end else if ({mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== {b_we, b_addr, b_be, b_wdata}) begin
          bus_stable = 1'b0;
        end
        req_cycles++;
      end
      if (done_o || err_o) begin
        saw_done = done_o; saw_err = err_o; lat = c + 1;
        break;
      end
      start_i     = restart && (c == 2);
      mem_ack_i   = mem_req_o && (ack_after >= 0) && (req_cycles == ack_after + 1);
      mem_rdata_i = mem_ack_i ? rd : 32'h0BAD_0BAD;
      @(posedge clk); #1;
      mem_ack_i = 1'b0; start_i = 1'b0;
    end
    @(posedge clk); #1;
    chk("pulse_clear", {29'd0, done_o, err_o, busy_o}, 32'd0);
    chk("bus_idle", {mem_req_o, mem_we_o, mem_be_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; ir_load_i = 1'b0; we_i = 1'b0; uns_i = 1'b0;
    size_i = 2'b00; addr_i = '0; wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_flags", {26'd0, mem_req_o, mem_we_o, busy_o, done_o, err_o, 1'b0}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_mdr", mdr_o, 32'd0);
    chk("rst_bus", {mem_be_o, mem_addr_o[27:0]} | mem_wdata_o, 32'd0);

    // Word fetch, 3 wait cycles
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 3, 32'h8C08_0004, 1'b0);
    chk("fetch_req_cycles", req_cycles, 4);
    chk("fetch_done", {saw_done, saw_err}, 32'd2);
    chk("fetch_latency", lat, 5);
    chk("fetch_addr", b_addr, 32'h0000_3000);
    chk("fetch_we_be", {b_we, b_be}, 32'h0F);
    chk("fetch_instr", instr_o, 32'h8C08_0004);
    chk("fetch_mdr", mdr_o, 32'd0);

    // lb / lbu at byte lane 3
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0, 32'h80FF_7F01, 1'b0);
    chk("lb_latency", lat, 2);
    chk("lb_addr", b_addr, 32'h10);
    chk("lb_mdr", mdr_o, 32'hFFFF_FF80);
    access(1'b0, 1'b0, 2'b10, 1'b1, 32'h13, 32'h0, 1, 32'h80FF_7F01, 1'b0);
    chk("lbu_mdr", mdr_o, 32'h0000_0080);
    access(1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, 32'h80FF_7F01, 1'b0);
    chk("lh_hi_mdr", mdr_o, 32'hFFFF_80FF);
    access(1'b0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0, 32'h80FF_7F01, 1'b0);
    chk("lhu_lo_mdr", mdr_o, 32'h0000_7F01);
    access(1'b0, 1'b0, 2'b11, 1'b0, 32'h24, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
    chk("lw_mdr", mdr_o, 32'hDEAD_BEEF);
    chk("lw_be", {b_we, b_be}, 32'h0F);
    chk("lw_instr_kept", instr_o, 32'h8C08_0004);

    // Stores
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 1, 32'h1234_5678, 1'b0);
    chk("sh_addr", b_addr, 32'h20);
    chk("sh_we_be", {b_we, b_be}, 32'h1C);
    chk("sh_wdata", b_wdata, 32'hBEEF_BEEF);
    chk("sh_stable", bus_stable, 1);
    chk("sh_mdr_kept", mdr_o, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h41, 32'h1234_56A5, 0, 32'h0, 1'b0);
    chk("sb_be", {b_we, b_be}, 32'h12);
    chk("sb_wdata", b_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", b_addr, 32'h40);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h50, 32'hCAFE_F00D, 0, 32'h0, 1'b0);
    chk("sw_be", {b_we, b_be}, 32'h1F);
    chk("sw_wdata", b_wdata, 32'hCAFE_F00D);

    // Misaligned requests
    access(1'b0, 1'b0, 2'b00, 1'b0, 32'h06, 32'h0, 0, 32'h0, 1'b0);
    chk("mis_lw_req", req_cycles, 0);
    chk("mis_lw_err", {saw_done, saw_err}, 32'd1);
    chk("mis_lw_latency", lat, 1);
    chk("mis_lw_mdr", mdr_o, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h23, 32'h0, 0, 32'h0, 1'b0);
    chk("mis_sh_err", {req_cycles[3:0], saw_done, saw_err}, 32'd1);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 0, 32'h0, 1'b0);
    chk("mis_fetch_err", {req_cycles[3:0], saw_done, saw_err}, 32'd1);

    // Timeout with a second start while busy
    access(1'b0, 1'b0, 2'b00, 1'b0, 32'h60, 32'h0, -1, 32'h0, 1'b1);
    chk("to_req_cycles", req_cycles, 15);
    chk("to_err", {saw_done, saw_err}, 32'd1);
    chk("to_latency", lat, 16);
    chk("to_stable", bus_stable, 1);
    chk("to_addr", b_addr, 32'h60);
    chk("to_mdr_kept", mdr_o, 32'hDEAD_BEEF);

    // Ack on the final allowed wait cycle
    access(1'b0, 1'b0, 2'b00, 1'b0, 32'h64, 32'h0, 14, 32'h0F0F_0F0F, 1'b0);
    chk("late_ack_done", {saw_done, saw_err}, 32'd2);
    chk("late_ack_req_cycles", req_cycles, 15);
    chk("late_ack_mdr", mdr_o, 32'h0F0F_0F0F);

    // Synchronous reset in the middle of a request
    ir_load_i = 1'b1; we_i = 1'b0; size_i = 2'b00; addr_i = 32'h3008; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; ir_load_i = 1'b0;
    chk("rstmid_req_before", {busy_o, mem_req_o}, 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_req", {busy_o, mem_req_o, done_o, err_o}, 32'd0);
    chk("rstmid_instr", instr_o, 32'd0);
    chk("rstmid_mdr", mdr_o, 32'd0);
    chk("rstmid_bus", {mem_we_o, mem_be_o} | mem_addr_o, 32'd0);

    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h3004, 32'h0, 1, 32'h1111_2222, 1'b0);
    chk("post_rst_fetch_done", {saw_done, saw_err}, 32'd2);
    chk("post_rst_fetch_latency", lat, 3);
    chk("post_rst_instr", instr_o, 32'h1111_2222);
    chk("post_rst_mdr", mdr_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
